// File: rtl/segment_sequencer.sv
// Steps an 8-entry 7-segment character buffer out to the animator, one character
// per dwell period measured in clk60 rising edges; one-shot or looping.
module segment_sequencer #(
  parameter logic [7:0] HOLD_TICKS = 8'd60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clk60,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [2:0] msg_last,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [6:0] wr_data,
  output logic [6:0] char_out,
  output logic       char_valid,
  output logic [2:0] char_index,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HOLD_LOAD = (HOLD_TICKS == 8'd0) ? 8'd1 : HOLD_TICKS;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_HOLD, S_NEXT} state_t;

  state_t     state_q, state_d;
  logic [6:0] char_out_q, char_out_d;
  logic [2:0] char_index_q, char_index_d;
  logic       char_valid_q, char_valid_d;
  logic       done_q, done_d;
  logic [7:0] timer_q, timer_d;
  logic       loop_q, loop_d;
  logic [2:0] last_q, last_d;
  logic       start_prev_q, start_prev_d;
  logic       clk60_prev_q, clk60_prev_d;
  logic [6:0] mem_q [8];

  logic start_edge, tick;

  assign start_edge = start & ~start_prev_q;
  assign tick       = clk60 & ~clk60_prev_q;

  always_comb begin
    state_d      = state_q;
    char_out_d   = char_out_q;
    char_index_d = char_index_q;
    char_valid_d = 1'b0;
    done_d       = 1'b0;
    timer_d      = timer_q;
    loop_d       = loop_q;
    last_d       = last_q;
    start_prev_d = start;
    clk60_prev_d = clk60;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_edge) begin
          loop_d       = loop;
          last_d       = msg_last;
          char_index_d = 3'd0;
          state_d      = S_LOAD;
        end
        S_LOAD: begin
          char_out_d = mem_q[char_index_q];
          state_d    = S_ISSUE;
        end
        S_ISSUE: begin
          char_valid_d = 1'b1;
          timer_d      = HOLD_LOAD;
          state_d      = S_HOLD;
        end
        S_HOLD: if (tick) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) state_d = S_NEXT;
        end
        S_NEXT: begin
          if (char_index_q != last_q) begin
            char_index_d = char_index_q + 3'd1;
            state_d      = S_LOAD;
          end else if (loop_q) begin
            char_index_d = 3'd0;
            state_d      = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      char_out_q   <= 7'd0;
      char_index_q <= 3'd0;
      char_valid_q <= 1'b0;
      done_q       <= 1'b0;
      timer_q      <= 8'd0;
      loop_q       <= 1'b0;
      last_q       <= 3'd0;
      start_prev_q <= 1'b0;
      clk60_prev_q <= 1'b0;
    end else if (enable) begin
      state_q      <= state_d;
      char_out_q   <= char_out_d;
      char_index_q <= char_index_d;
      char_valid_q <= char_valid_d;
      done_q       <= done_d;
      timer_q      <= timer_d;
      loop_q       <= loop_d;
      last_q       <= last_d;
      start_prev_q <= start_prev_d;
      clk60_prev_q <= clk60_prev_d;
    end
  end

  // Buffer is deliberately not reset so a message survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (enable && wr_en && state_q == S_IDLE) mem_q[wr_addr] <= wr_data;
  end

  assign char_out   = char_out_q;
  assign char_index = char_index_q;
  assign char_valid = char_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed bench for segment_sequencer: cycle-exact vector table plus
// multi-cycle sequences for one-shot, loop, stop, reset and enable.
module tb_segment_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, clk60, start, stop, loop;
  logic [2:0] msg_last, wr_addr;
  logic       wr_en;
  logic [6:0] wr_data;
  logic [6:0] char_out;
  logic       char_valid, busy, done;
  logic [2:0] char_index;

  segment_sequencer #(.HOLD_TICKS(8'd3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clk60(clk60), .start(start),
    .stop(stop), .loop(loop), .msg_last(msg_last), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .char_out(char_out),
    .char_valid(char_valid), .char_index(char_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic gen_on = 1'b0;
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (gen_on) begin
        cnt++;
        clk60 = (cnt % 20 == 0);
      end
    end
  end

  logic [6:0] q_out [$];
  logic [2:0] q_idx [$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (char_valid) begin
      q_out.push_back(char_out);
      q_idx.push_back(char_index);
    end
    if (done) done_cnt++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic run_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int lim);
    int k = 0;
    while (q_out.size() < n && k < lim) begin @(negedge clk); k++; end
    chk("wait_pulses", 32'(q_out.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin @(negedge clk); k++; end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic tick();
    @(negedge clk); clk60 = 1'b1;
    @(negedge clk); clk60 = 1'b0;
  endtask

  typedef struct {
    logic st, sp, c60, we;
    logic [2:0] wa;
    logic [6:0] wd;
    logic e_busy, e_cv, e_dn;
    logic [6:0] e_out;
    logic [2:0] e_idx;
  } vec_t;
  vec_t tv [21];

  initial begin
    int b, bd, n;
    logic [6:0] exp_o [5];
    logic [2:0] exp_i [5];

    // Row i inputs are sampled at posedge i; expectations are the outputs after it.
    tv[0]  = '{0,0,0,0,3'd0,7'h00, 0,0,0,7'h00,3'd0};
    tv[1]  = '{1,0,0,0,3'd0,7'h00, 1,0,0,7'h00,3'd0};
    tv[2]  = '{1,0,0,0,3'd0,7'h00, 1,0,0,7'h3F,3'd0};
    tv[3]  = '{0,0,0,0,3'd0,7'h00, 1,1,0,7'h3F,3'd0};
    tv[4]  = '{0,0,1,0,3'd0,7'h00, 1,0,0,7'h3F,3'd0};
    tv[5]  = '{0,0,1,0,3'd0,7'h00, 1,0,0,7'h3F,3'd0};
    tv[6]  = '{0,0,0,0,3'd0,7'h00, 1,0,0,7'h3F,3'd0};
    tv[7]  = '{0,0,1,0,3'd0,7'h00, 1,0,0,7'h3F,3'd0};
    tv[8]  = '{0,0,0,0,3'd0,7'h00, 1,0,0,7'h3F,3'd0};
    tv[9]  = '{0,0,1,0,3'd0,7'h00, 1,0,0,7'h3F,3'd0};
    tv[10] = '{0,0,0,0,3'd0,7'h00, 1,0,0,7'h3F,3'd1};
    tv[11] = '{0,0,0,0,3'd0,7'h00, 1,0,0,7'h06,3'd1};
    tv[12] = '{1,0,1,1,3'd1,7'h7F, 1,1,0,7'h06,3'd1};
    tv[13] = '{0,0,0,0,3'd0,7'h00, 1,0,0,7'h06,3'd1};
    tv[14] = '{0,0,1,0,3'd0,7'h00, 1,0,0,7'h06,3'd1};
    tv[15] = '{0,0,0,0,3'd0,7'h00, 1,0,0,7'h06,3'd1};
    tv[16] = '{0,0,1,0,3'd0,7'h00, 1,0,0,7'h06,3'd1};
    tv[17] = '{0,0,0,0,3'd0,7'h00, 1,0,0,7'h06,3'd1};
    tv[18] = '{0,0,1,0,3'd0,7'h00, 1,0,0,7'h06,3'd1};
    tv[19] = '{0,0,0,0,3'd0,7'h00, 0,0,1,7'h06,3'd1};
    tv[20] = '{0,0,0,0,3'd0,7'h00, 0,0,0,7'h06,3'd1};

    reset = 1'b1; enable = 1'b1; clk60 = 1'b0; start = 1'b0; stop = 1'b0;
    loop = 1'b0; msg_last = 3'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 7'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst busy", 32'(busy), 0);
    chk("rst char_out", 32'(char_out), 0);
    chk("rst char_index", 32'(char_index), 0);
    chk("rst char_valid", 32'(char_valid), 0);
    chk("rst done", 32'(done), 0);

    wr(3'd0, 7'h3F); wr(3'd1, 7'h06); wr(3'd2, 7'h5B);

    // Latency, ISSUE-cycle tick, ignored write/start while busy, one-shot end.
    msg_last = 3'd1; loop = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      start = tv[i].st; stop = tv[i].sp; clk60 = tv[i].c60;
      wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("vec%0d char_valid", i), 32'(char_valid), 32'(tv[i].e_cv));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tv[i].e_dn));
      chk($sformatf("vec%0d char_out", i), 32'(char_out), 32'(tv[i].e_out));
      chk($sformatf("vec%0d char_index", i), 32'(char_index), 32'(tv[i].e_idx));
    end
    @(negedge clk); start = 1'b0; clk60 = 1'b0; wr_en = 1'b0;
    gen_on = 1'b1;

    // One-shot of three characters; buf[1] must still be 0x06.
    b = q_out.size(); bd = done_cnt;
    msg_last = 3'd2; loop = 1'b0;
    run_start();
    wait_pulses(b + 3, 1000);
    wait_idle(1000);
    @(negedge clk);
    exp_o = '{7'h3F, 7'h06, 7'h5B, 7'h00, 7'h00};
    exp_i = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    if (q_out.size() >= b + 3)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("oneshot char%0d", k), 32'(q_out[b+k]), 32'(exp_o[k]));
        chk($sformatf("oneshot index%0d", k), 32'(q_idx[b+k]), 32'(exp_i[k]));
      end
    chk("oneshot pulse count", 32'(q_out.size() - b), 32'd3);
    chk("oneshot done count", 32'(done_cnt - bd), 32'd1);
    chk("oneshot busy", 32'(busy), 0);
    chk("oneshot char_out held", 32'(char_out), 32'h5B);

    // Write in IDLE takes effect.
    wr(3'd1, 7'h7F);
    b = q_out.size(); msg_last = 3'd1;
    run_start();
    wait_idle(1000);
    @(negedge clk);
    chk("idle write count", 32'(q_out.size() - b), 32'd2);
    if (q_out.size() >= b + 2) chk("idle write char1", 32'(q_out[b+1]), 32'h7F);
    wr(3'd1, 7'h06);

    // Loop wrap with msg_last = 1.
    b = q_out.size(); bd = done_cnt;
    msg_last = 3'd1; loop = 1'b1;
    run_start();
    wait_pulses(b + 5, 2000);
    exp_o = '{7'h3F, 7'h06, 7'h3F, 7'h06, 7'h3F};
    exp_i = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
    if (q_out.size() >= b + 5)
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("loop char%0d", k), 32'(q_out[b+k]), 32'(exp_o[k]));
        chk($sformatf("loop index%0d", k), 32'(q_idx[b+k]), 32'(exp_i[k]));
      end
    chk("loop no done", 32'(done_cnt - bd), 32'd0);
    chk("loop busy", 32'(busy), 32'd1);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(10);

    // Stop during the second HOLD.
    b = q_out.size(); bd = done_cnt;
    run_start();
    wait_pulses(b + 2, 500);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #1;
    chk("stop busy", 32'(busy), 0);
    chk("stop char_out", 32'(char_out), 32'h06);
    chk("stop char_valid", 32'(char_valid), 0);
    @(negedge clk); stop = 1'b0;
    n = q_out.size();
    repeat (100) @(negedge clk);
    chk("stop no more pulses", 32'(q_out.size()), 32'(n));
    chk("stop no done", 32'(done_cnt - bd), 32'd0);
    chk("stop stays idle", 32'(busy), 0);

    // Reset mid-HOLD, buffer retained.
    b = q_out.size();
    msg_last = 3'd2; loop = 1'b0;
    run_start();
    wait_pulses(b + 1, 500);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst char_out", 32'(char_out), 0);
    chk("midrst char_index", 32'(char_index), 0);
    chk("midrst char_valid", 32'(char_valid), 0);
    chk("midrst done", 32'(done), 0);
    @(negedge clk); reset = 1'b0;
    b = q_out.size(); bd = done_cnt;
    msg_last = 3'd0;
    run_start();
    wait_idle(1000);
    @(negedge clk);
    chk("postrst count", 32'(q_out.size() - b), 32'd1);
    if (q_out.size() >= b + 1) chk("postrst buf0", 32'(q_out[b]), 32'h3F);
    chk("postrst done", 32'(done_cnt - bd), 32'd1);

    // Enable low across two ticks freezes the dwell timer.
    @(negedge clk); gen_on = 1'b0; #1 clk60 = 1'b0;
    b = q_out.size(); bd = done_cnt;
    msg_last = 3'd0; loop = 1'b0;
    run_start();
    wait_pulses(b + 1, 20);
    tick();
    @(negedge clk); enable = 1'b0;
    tick(); tick();
    repeat (3) @(negedge clk);
    enable = 1'b1;
    tick();
    @(negedge clk);
    chk("enable timer frozen busy", 32'(busy), 32'd1);
    chk("enable no early done", 32'(done_cnt - bd), 32'd0);
    tick();
    repeat (3) @(negedge clk);
    chk("enable final idle", 32'(busy), 0);
    chk("enable done", 32'(done_cnt - bd), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
